// File: rtl/cpu_program_loader.sv
// Boot loader: buffers a byte-stream program, then burst-loads it into the
// CPU instruction memory and sequences the CPU reset around the burst.
module cpu_program_loader #(
    parameter int MAX_WORDS   = 32,
    parameter int HOLD_CYCLES = 2,
    localparam int CW = $clog2(MAX_WORDS + 1),
    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          LoadInstructions,
    output logic [31:0]   Instruction,
    output logic          CpuReset,
    output logic [CW-1:0] word_count,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FILL,
        S_PRE,
        S_BURST,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [8:0] MAX_HDR = 9'(MAX_WORDS);

    state_t          state_q;
    logic [1:0]      bcnt_q;
    logic [AW-1:0]   widx_q;
    logic [CW-1:0]   kidx_q;
    logic [HW-1:0]   hcnt_q;
    logic [23:0]     shift_q;
    logic            ready_q;
    logic            load_q;
    logic [31:0]     instr_q;
    logic            cpurst_q;
    logic [CW-1:0]   wc_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [31:0]     mem_q [MAX_WORDS];

    logic            accept_d;
    logic            wr_en_d;
    logic            last_d;
    logic            hdr_bad_d;
    logic [CW-1:0]   widx_nx_d;

    // Byte acceptance and word-completion decode
    always_comb begin
        accept_d  = ready_q & byte_valid;
        wr_en_d   = accept_d && (state_q == S_FILL) && (bcnt_q == 2'd3);
        widx_nx_d = CW'(widx_q) + CW'(1);
        last_d    = wr_en_d && (widx_nx_d == wc_q);
        hdr_bad_d = (byte_data == 8'd0) || ({1'b0, byte_data} > MAX_HDR);
    end

    // Program buffer; deliberately not reset so stale words simply persist
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[widx_q] <= {shift_q, byte_data};
        end
    end

    // Session FSM with all outputs registered
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            bcnt_q   <= '0;
            widx_q   <= '0;
            kidx_q   <= '0;
            hcnt_q   <= '0;
            shift_q  <= '0;
            ready_q  <= 1'b0;
            load_q   <= 1'b0;
            instr_q  <= '0;
            cpurst_q <= 1'b1;
            wc_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_RUN, S_ERR: begin
                    if (start) begin
                        state_q  <= S_HDR;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        cpurst_q <= 1'b1;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept_d) begin
                        if (hdr_bad_d) begin
                            state_q <= S_ERR;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                            wc_q    <= CW'(byte_data);
                            bcnt_q  <= '0;
                            widx_q  <= '0;
                        end
                    end
                end
                S_FILL: begin
                    if (accept_d) begin
                        bcnt_q  <= bcnt_q + 2'd1;
                        shift_q <= {shift_q[15:0], byte_data};
                        if (bcnt_q == 2'd3) begin
                            widx_q <= widx_q + AW'(1);
                        end
                        if (last_d) begin
                            state_q <= S_PRE;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_PRE: begin
                    state_q  <= S_BURST;
                    load_q   <= 1'b1;
                    instr_q  <= mem_q[0];
                    cpurst_q <= 1'b0;
                    kidx_q   <= CW'(1);
                end
                S_BURST: begin
                    if (kidx_q == wc_q) begin
                        state_q  <= S_HOLD;
                        load_q   <= 1'b0;
                        instr_q  <= '0;
                        cpurst_q <= 1'b1;
                        hcnt_q   <= '0;
                    end else begin
                        instr_q <= mem_q[kidx_q[AW-1:0]];
                        kidx_q  <= kidx_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
                        state_q  <= S_RUN;
                        cpurst_q <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready       = ready_q;
    assign LoadInstructions = load_q;
    assign Instruction      = instr_q;
    assign CpuReset         = cpurst_q;
    assign word_count       = wc_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = err_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: burst words are checked against a
// scoreboard filled as the byte stream is driven.
module tb_cpu_program_loader;

    localparam int MAXW = 32;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        LoadInstructions;
    logic [31:0] Instruction;
    logic        CpuReset;
    logic [5:0]  word_count;
    logic        busy;
    logic        done;
    logic        error;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb [$];
    logic [31:0] prog [MAXW];

    cpu_program_loader #(.MAX_WORDS(MAXW), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk),
        .Reset(Reset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .LoadInstructions(LoadInstructions),
        .Instruction(Instruction),
        .CpuReset(CpuReset),
        .word_count(word_count),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Burst monitor: every load cycle pops one expected word
    always @(negedge clk) begin
        if (LoadInstructions === 1'b1) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_load: got %h want no load", Instruction);
            end
            if (sb.size() != 0) chk("burst_word", Instruction, sb.pop_front());
            chk("burst_cpurst", 32'(CpuReset), 32'd0);
        end else begin
            chk("instr_idle_zero", Instruction, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit acc;
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        byte_valid = 1'b0;
        repeat (g) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        acc = 1'b0;
        for (int w = 0; w < 50 && !acc; w++) begin
            acc = byte_ready;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("byte_accept", 32'(acc), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hdr_ready", 32'(byte_ready), 32'd1);
        chk("hdr_cpurst", 32'(CpuReset), 32'd1);
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_done", 32'(done), 32'd0);
        chk("hdr_error", 32'(error), 32'd0);
    endtask

    // Full session starting in HDR; checks the post-stream timeline
    task automatic session(input int n, input int maxgap);
        logic [31:0] wd;
        send_byte(8'(n), maxgap);
        for (int i = 0; i < n; i++) begin
            wd = prog[i];
            sb.push_back(wd);
            for (int b = 0; b < 4; b++) begin
                send_byte(wd[31-8*b -: 8], maxgap);
            end
        end
        chk("pre_ready", 32'(byte_ready), 32'd0);
        chk("pre_cpurst", 32'(CpuReset), 32'd1);
        chk("pre_load", 32'(LoadInstructions), 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("burst_load", 32'(LoadInstructions), 32'd1);
        end
        for (int h = 0; h < HOLD; h++) begin
            @(negedge clk);
            chk("hold_load", 32'(LoadInstructions), 32'd0);
            chk("hold_cpurst", 32'(CpuReset), 32'd1);
            chk("hold_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("run_done", 32'(done), 32'd1);
        chk("run_cpurst", 32'(CpuReset), 32'd0);
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_wc", 32'(word_count), 32'(n));
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cpurst", 32'(CpuReset), 32'd1);
        chk("rst_load", 32'(LoadInstructions), 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        Reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // Reset mid-FILL, then N=2
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        #2 Reset = 1'b0;
        #1 chk_reset_vals();
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(byte_ready), 32'd0);
        prog[0] = 32'h11223344;
        prog[1] = 32'hDEADBEEF;
        pulse_start();
        session(2, 0);

        // N=1 basic
        prog[0] = 32'h20010005;
        pulse_start();
        session(1, 0);

        // Reload from RUN with N=3
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        pulse_start();
        session(3, 0);

        // Bad headers
        pulse_start();
        send_byte(8'h00, 0);
        chk("err0_flag", 32'(error), 32'd1);
        chk("err0_ready", 32'(byte_ready), 32'd0);
        chk("err0_cpurst", 32'(CpuReset), 32'd1);
        repeat (3) @(negedge clk);
        chk("err0_hold", 32'(error), 32'd1);
        pulse_start();
        send_byte(8'h21, 0);
        chk("err21_flag", 32'(error), 32'd1);
        chk("err21_ready", 32'(byte_ready), 32'd0);

        // N=MAX with random gaps
        for (int i = 0; i < MAXW; i++) prog[i] = $urandom;
        pulse_start();
        session(MAXW, 2);

        // Reset on burst cycle 2 of N=4
        for (int i = 0; i < 4; i++) prog[i] = $urandom;
        pulse_start();
        send_byte(8'd4, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) sb.push_back(prog[i]);
            for (int b = 0; b < 4; b++) send_byte(prog[i][31-8*b -: 8], 0);
        end
        repeat (3) @(negedge clk);
        #2 Reset = 1'b0;
        #1 chk_reset_vals();
        chk("midburst_sb", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        chk("midburst_idle", 32'(byte_ready), 32'd0);
        pulse_start();
        session(4, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_program_loader.md
# cpu_program_loader

Upstream boot loader for the pipelined CPU: receives a program as a byte stream over a valid/ready handshake, buffers it, then drives the CPU's `LoadInstructions`/`Instruction` load port and `Reset` input. Its outputs connect to those CPU pins, so instruction memory is filled from address 0 by the CPU's free-running load counter. The CPU is held in reset afterwards and then released to execute.

## Interface
- `MAX_WORDS`, 32: instruction-memory depth in words; the buffer holds this many words.
- `HOLD_CYCLES`, 2: cycles the CPU is held in reset after the burst, ≥1.
- `clk` in 1: single clock, rising edge.
- `Reset` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: pulse; begins a load session.
- `byte_valid` in 1, `byte_data` in 8: program byte stream.
- `byte_ready` out 1: loader accepts a byte when `byte_valid && byte_ready`.
- `LoadInstructions` out 1: to CPU `LoadInstructions`.
- `Instruction` out 32: to CPU `Instruction`.
- `CpuReset` out 1: active-high, to CPU `Reset`.
- `word_count` out $clog2(MAX_WORDS+1): header word count N of the current session.
- `busy` out 1: session in progress.
- `done` out 1: program loaded, CPU running.
- `error` out 1: bad header.

## Operation
- Stream format: 1 header byte N (valid range 1..MAX_WORDS), then 4N bytes.
  - Each word is big-endian: first byte is bits [31:24].
  - Words are stored in arrival order at buffer index 0..N-1.
- IDLE: `CpuReset`=1, `byte_ready`=0. `start` -> HDR.
- HDR: `byte_ready`=1, `busy`=1, `CpuReset`=1. Accepted byte:
  - 0 or >MAX_WORDS -> ERROR;
  - otherwise latch `word_count`=N and go to FILL.
- FILL: `byte_ready`=1, `CpuReset`=1.
  - A 2-bit byte counter and a word index advance only on accepted bytes.
  - On the 4N-th accepted byte -> PRELOAD; `byte_ready` drops the next cycle.
- PRELOAD: one cycle; `CpuReset`=1, `byte_ready`=0. This zeroes the CPU load counter.
- BURST: N cycles; `CpuReset`=0, `LoadInstructions`=1, `Instruction`=word[k] on burst cycle k (k=0..N-1). Then -> HOLD.
- HOLD: HOLD_CYCLES cycles; `CpuReset`=1, `LoadInstructions`=0. This flushes the PC, pipeline and register file. Then -> RUN.
- RUN: `CpuReset`=0, `done`=1, `busy`=0. `start` -> HDR, which reasserts `CpuReset` and clears `done`.
- ERROR: `error`=1, `CpuReset`=1, `byte_ready`=0. `start` -> HDR and clears `error`.
- `start` is ignored in HDR, FILL, PRELOAD, BURST and HOLD.
- `byte_valid` is ignored whenever `byte_ready`=0, and no byte is consumed.
- `Instruction` is 0 whenever `LoadInstructions`=0.
- Buffer contents beyond N are stale but are never driven out.

## Timing
- All outputs are registered; `byte_ready` is a function of state only, so there is no combinational path from input to output.
- Async assert of `Reset` (low), in any state including mid-FILL or mid-BURST:
  - immediately forces IDLE;
  - `CpuReset`=1, `LoadInstructions`=0, `Instruction`=0;
  - `byte_ready`, `busy`, `done`, `error` = 0; `word_count`=0;
  - byte counter and word index = 0.
  - A partial session is discarded. The buffer array is not reset.
- Deassertion is sampled at the next clock edge; the loader stays in IDLE until `start`.
- `start` high at edge t in IDLE -> HDR visible at t+1 (`byte_ready`=1).
- Last data byte accepted at edge t:
  - PRELOAD during (t, t+1];
  - `LoadInstructions` high for edges t+2 .. t+1+N;
  - `CpuReset` high for edges t+2+N .. t+1+N+HOLD_CYCLES;
  - `done`=1 from edge t+2+N+HOLD_CYCLES.
- Minimum session length: 1 + 4N accepted bytes, plus N + HOLD_CYCLES + 1 cycles after the last byte.
- Back-to-back bytes (`byte_valid` held high) are accepted one per cycle with no bubbles.

## Test plan
- Reset mid-operation: hold `Reset` low for 3 cycles mid-stream -> outputs at reset values immediately. A subsequent `start` plus a full stream with N=2 loads correctly.
- N=1 basic load: send 0x01, 0x20,0x01,0x00,0x05, no gaps -> exactly one cycle with `LoadInstructions`=1 and `Instruction`=0x20010005, preceded by 1 PRELOAD cycle and followed by 2 `CpuReset` cycles. `done`=1 after that.
- N=MAX_WORDS with random `byte_valid` gaps -> 32 consecutive `LoadInstructions` cycles. Each word matches the sent order and big-endian packing. `word_count`=32.
- Bad header: header 0x00, then 0x21 (with MAX_WORDS=32) -> `error`=1, `byte_ready`=0, `CpuReset`=1, and no `LoadInstructions` pulse. `start` clears `error`.
- Reset mid-BURST: assert `Reset` on burst cycle 2 of N=4 -> `LoadInstructions` drops at once and the loader is in IDLE after release. A subsequent full session completes with all 4 words.
- Reload from RUN: `start` in RUN -> `CpuReset`=1 and `done`=0 on the next cycle. A second program of N=3 bursts 3 words starting at the cycle after PRELOAD.
